// File: rtl/quad_rd_scheduler_if.sv
// ----------------------------------------------------------------------------
// quad_rd_scheduler_if
//
// Bundle of the FIFO-side and pixel-side handshake signals of the quadrant
// read scheduler.
//
//   fifo_prefill[3:0]  per-quadrant fill threshold reached (bit0=A .. bit3=D)
//   fifo_empty[3:0]    per-quadrant FIFO empty, same bit order
//   sink_ready         downstream accepts a pixel this cycle
//   fifo_rd_en[3:0]    one-hot read strobe to the quadrant FIFOs
//   pix_valid          FIFO output data valid (one cycle after the read)
//   pix_sof            first pixel of frame, qualified by pix_valid
//   pix_eol            last pixel of line, qualified by pix_valid
//
// Modports:
//   master - the scheduler (drives read strobe and pixel flags)
//   slave  - the FIFO bank / sink side
// ----------------------------------------------------------------------------
interface quad_rd_scheduler_if;
    logic [3:0] fifo_prefill;
    logic [3:0] fifo_empty;
    logic       sink_ready;
    logic [3:0] fifo_rd_en;
    logic       pix_valid;
    logic       pix_sof;
    logic       pix_eol;

    modport master (
        input  fifo_prefill, fifo_empty, sink_ready,
        output fifo_rd_en, pix_valid, pix_sof, pix_eol
    );

    modport slave (
        output fifo_prefill, fifo_empty, sink_ready,
        input  fifo_rd_en, pix_valid, pix_sof, pix_eol
    );
endinterface

// File: rtl/quad_rd_scheduler.sv
// ----------------------------------------------------------------------------
// quad_rd_scheduler
//
// Reads one video frame out of four quadrant FIFOs (A top-left, B top-right,
// C bottom-left, D bottom-right) in raster order, one pixel per read.
// A frame request waits in FILL until all four FIFOs report prefill, then
// ACTIVE issues one-hot reads whenever the sink is ready and the selected
// FIFO is non-empty. A sticky underrun flag records starvation.
//
// Ports:
//   pclk_div2    single clock, rising edge
//   sys_rst_n    asynchronous active-low reset
//   frame_start  request one frame (honoured in IDLE only)
//   abort        terminate the frame, return to IDLE
//   bus          quad_rd_scheduler_if.master (FIFO and pixel handshakes)
//   busy         state is not IDLE
//   frame_done   one-cycle completion pulse
//   underrun     sticky starvation flag, cleared at the next frame start
//   underrun_cnt (only with QRS_UNDERRUN_CNT_EN) saturating starvation count
//
// Optional feature: define QRS_UNDERRUN_CNT_EN to add underrun_cnt.
// ----------------------------------------------------------------------------
module quad_rd_scheduler #(
    parameter int H_ACT   = 1920,
    parameter int V_ACT   = 1080,
    parameter int H_SPLIT = 960,
    parameter int V_SPLIT = 540
) (
    input  logic                 pclk_div2,
    input  logic                 sys_rst_n,
    input  logic                 frame_start,
    input  logic                 abort,
    quad_rd_scheduler_if.master  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underrun
`ifdef QRS_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          underrun_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

    localparam logic [11:0] H_LAST = 12'(H_ACT - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACT - 1);
    localparam logic [11:0] H_SPL  = 12'(H_SPLIT);
    localparam logic [11:0] V_SPL  = 12'(V_SPLIT);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [1:0]  sel;
    logic        rd;
    logic        starve;
    logic        start;
    logic        line_end;

    // Quadrant index doubles as the bit position in the FIFO vectors:
    // bit1 = bottom half, bit0 = right half, so A=0, B=1, C=2, D=3.
    always_comb begin
        sel      = {(v_cnt >= V_SPL), (h_cnt >= H_SPL)};
        line_end = (h_cnt == H_LAST);
    end

    // Next-state and read strobe. Abort wins over everything, including the
    // final read of a frame, so an aborted frame never reaches DONE.
    always_comb begin
        state_nxt      = state;
        rd             = 1'b0;
        starve         = 1'b0;
        start          = 1'b0;
        bus.fifo_rd_en = 4'b0000;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state_nxt = FILL;
                        start     = 1'b1;
                    end
                end
                FILL: begin
                    if (bus.fifo_prefill == 4'b1111) begin
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.sink_ready) begin
                        if (bus.fifo_empty[sel]) begin
                            starve = 1'b1;
                        end else begin
                            rd             = 1'b1;
                            bus.fifo_rd_en = 4'b0001 << sel;
                            if (line_end && (v_cnt == V_LAST)) begin
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE) && !abort;
    end

    always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Raster position only moves on an actual read, so stalls and
    // starvation hold the position of the pending pixel.
    always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (abort || start) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (rd) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Pixel flags line up with the FIFO's one-cycle read latency.
    always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.pix_valid <= 1'b0;
            bus.pix_sof   <= 1'b0;
            bus.pix_eol   <= 1'b0;
        end else begin
            bus.pix_valid <= rd;
            bus.pix_sof   <= rd && (h_cnt == 12'd0) && (v_cnt == 12'd0);
            bus.pix_eol   <= rd && line_end;
        end
    end

    always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun <= 1'b0;
        end else if (start) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end
    end

`ifdef QRS_UNDERRUN_CNT_EN
    // Counts every starved cycle and sticks at all-ones rather than wrapping.
    always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun_cnt <= '0;
        end else if (start) begin
            underrun_cnt <= '0;
        end else if (starve && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
